cirno_control: RTL and testbench

- Multi-cycle fetch/decode/sequencing unit for the Cirno 8-bit core.
- Fetches 8-bit instructions over a valid/req handshake and decodes them.
- Drives the register file's select, immediate and enable inputs, and selects the ALU operation.
- Sits directly upstream of the register file; the ALU result feeds back to the register file, not through this block.

---
 rtl/cirno_pkg.sv | 41 ++++
 rtl/cirno_control_if.sv | 39 +++
 rtl/cirno_decode.sv | 43 ++++
 rtl/cirno_control.sv | 129 ++++++++++++
 tb/tb_cirno_control.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cirno_pkg.sv
// Shared types and encoding constants for the Cirno 8-bit core control path.
package cirno_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MOV,
    CLS_HALT,
    CLS_NOP,
    CLS_LHI,
    CLS_LLO
  } instr_class_t;

  // Top two opcode bits
  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_MISC = 2'b01;
  localparam logic [1:0] OP_LHI  = 2'b10;
  localparam logic [1:0] OP_LLO  = 2'b11;

  // MISC sub-op in IR[5:4]; 2'b10 and 2'b11 are both NOP
  localparam logic [1:0] MISC_MOV  = 2'b00;
  localparam logic [1:0] MISC_HALT = 2'b01;

  localparam logic [7:0] NOP_INSTR = 8'h60;

endpackage

// File: rtl/cirno_control_if.sv
// Fetch handshake and register-file control bundle between cirno_control and its neighbours.
interface cirno_control_if
  import cirno_pkg::*;
#(
  parameter int PC_W = 8
) ();

  logic [PC_W-1:0] pc;
  logic            instr_req;
  logic            instr_valid;
  logic [7:0]      instr_data;
  logic [1:0]      r1;
  logic [1:0]      r2;
  logic [5:0]      immediate;
  alu_op_t         alu_op;
  logic            reg_r_en;
  logic            reg_readx_en;
  logic            reg_ready_en;
  logic            reg_w_en;
  logic            reg_hi_en;
  logic            reg_lo_en;
  logic            reg_swap_en;
  logic            halted;

  modport master (
    output pc, instr_req, r1, r2, immediate, alu_op,
    output reg_r_en, reg_readx_en, reg_ready_en, reg_w_en,
    output reg_hi_en, reg_lo_en, reg_swap_en, halted,
    input  instr_valid, instr_data
  );

  modport slave (
    input  pc, instr_req, r1, r2, immediate, alu_op,
    input  reg_r_en, reg_readx_en, reg_ready_en, reg_w_en,
    input  reg_hi_en, reg_lo_en, reg_swap_en, halted,
    output instr_valid, instr_data
  );

endinterface

// File: rtl/cirno_decode.sv
// Pure combinational decode of the latched instruction into class, register selects, imm4 and ALU op.
module cirno_decode
  import cirno_pkg::*;
(
  input  logic [7:0]   ir,
  output instr_class_t cls,
  output logic [1:0]   r1,
  output logic [1:0]   r2,
  output logic [3:0]   imm4,
  output alu_op_t      alu_op
);

  always_comb begin
    cls    = CLS_NOP;
    r1     = ir[3:2];
    r2     = ir[1:0];
    imm4   = ir[3:0];
    alu_op = alu_op_t'(ir[5:4]);
    case (ir[7:6])
      OP_ALU:  cls = CLS_ALU;
      OP_MISC: begin
        if (ir[5:4] == MISC_MOV)
          cls = CLS_MOV;
        else if (ir[5:4] == MISC_HALT)
          cls = CLS_HALT;
        else
          cls = CLS_NOP;
      end
      OP_LHI: begin
        cls = CLS_LHI;
        r1  = ir[5:4];
        r2  = 2'b00;
      end
      OP_LLO: begin
        cls = CLS_LLO;
        r1  = ir[5:4];
        r2  = 2'b00;
      end
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/cirno_control.sv
// Fetch/decode/sequencing FSM for the Cirno 8-bit core; holds IR and pc.
// Optional CIRNO_CTRL_TRACE_EN adds retire_valid/retire_pc trace outputs.
module cirno_control
  import cirno_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  cirno_control_if.master bus
`ifdef CIRNO_CTRL_TRACE_EN
  ,
  output logic            retire_valid,
  output logic [PC_W-1:0] retire_pc
`endif
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [7:0]      ir_reg, ir_next;

  instr_class_t cls;
  logic [1:0]   dec_r1;
  logic [1:0]   dec_r2;
  logic [3:0]   dec_imm4;
  alu_op_t      dec_alu_op;

  logic instr_req;
  logic r_en, readx_en, ready_en;
  logic w_en, hi_en, lo_en, swap_en;
  logic halted;

  cirno_decode u_decode (
    .ir     (ir_reg),
    .cls    (cls),
    .r1     (dec_r1),
    .r2     (dec_r2),
    .imm4   (dec_imm4),
    .alu_op (dec_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= NOP_INSTR;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    instr_req  = 1'b0;
    r_en       = 1'b0;
    readx_en   = 1'b0;
    ready_en   = 1'b0;
    w_en       = 1'b0;
    hi_en      = 1'b0;
    lo_en      = 1'b0;
    swap_en    = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        instr_req = 1'b1;
        if (bus.instr_valid) begin
          ir_next    = bus.instr_data;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          CLS_ALU:  state_next = S_READ;
          CLS_HALT: state_next = S_HALT;
          CLS_NOP: begin
            pc_next    = pc_reg + 1'b1;
            state_next = S_FETCH;
          end
          default:  state_next = S_WRITE;
        endcase
      end
      S_READ: begin
        r_en       = 1'b1;
        readx_en   = 1'b1;
        ready_en   = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: state_next = S_WRITE;
      S_WRITE: begin
        w_en       = (cls == CLS_ALU);
        swap_en    = (cls == CLS_MOV);
        hi_en      = (cls == CLS_LHI);
        lo_en      = (cls == CLS_LLO);
        pc_next    = pc_reg + 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  assign bus.pc           = pc_reg;
  assign bus.instr_req    = instr_req;
  assign bus.r1           = dec_r1;
  assign bus.r2           = dec_r2;
  assign bus.immediate    = {2'b00, dec_imm4};
  assign bus.alu_op       = dec_alu_op;
  assign bus.reg_r_en     = r_en;
  assign bus.reg_readx_en = readx_en;
  assign bus.reg_ready_en = ready_en;
  assign bus.reg_w_en     = w_en;
  assign bus.reg_hi_en    = hi_en;
  assign bus.reg_lo_en    = lo_en;
  assign bus.reg_swap_en  = swap_en;
  assign bus.halted       = halted;

`ifdef CIRNO_CTRL_TRACE_EN
  // Retirement is known one cycle early: WRITE and NOP/HALT decode always exit next edge
  assign retire_valid = (state_reg == S_WRITE) ||
                        ((state_reg == S_DECODE) && ((cls == CLS_NOP) || (cls == CLS_HALT)));
  assign retire_pc    = pc_reg;
`endif

endmodule

// File: tb/tb_cirno_control.sv
// Directed self-checking bench for cirno_control; optional trace checks under CIRNO_CTRL_TRACE_EN.
module tb_cirno_control;
  import cirno_pkg::*;

  localparam logic [6:0] EN_NONE = 7'b000_0000;
  localparam logic [6:0] EN_READ = 7'b111_0000;
  localparam logic [6:0] EN_W    = 7'b000_1000;
  localparam logic [6:0] EN_HI   = 7'b000_0100;
  localparam logic [6:0] EN_LO   = 7'b000_0010;
  localparam logic [6:0] EN_SWAP = 7'b000_0001;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cirno_control_if #(.PC_W(8)) bus ();

`ifdef CIRNO_CTRL_TRACE_EN
  logic       retire_valid;
  logic [7:0] retire_pc;
  cirno_control #(.PC_W(8), .RESET_PC(8'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc)
  );
`else
  cirno_control #(.PC_W(8), .RESET_PC(8'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  wire [6:0] en = {bus.reg_r_en, bus.reg_readx_en, bus.reg_ready_en, bus.reg_w_en,
                   bus.reg_hi_en, bus.reg_lo_en, bus.reg_swap_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.pc); end
    n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL reset_en: got %b want %b", en, EN_NONE); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    n_checks++; if (bus.immediate !== 6'h00) begin n_fail++; $display("FAIL reset_imm: got %h want 00", bus.immediate); end
    rst_n = 1'b1;
    cyc();
    n_checks++; if (bus.instr_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", bus.instr_req); end
    n_checks++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc_after: got %0d want 0", bus.pc); end
    $display("test_reset: done, pc=%0d", bus.pc);
  endtask

  task automatic test_alu();
    logic [7:0] instrs [2] = '{8'h06, 8'h3B};
    logic [1:0] ops    [2] = '{2'b00, 2'b11};
    logic [1:0] r1s    [2] = '{2'd1, 2'd2};
    logic [1:0] r2s    [2] = '{2'd2, 2'd3};
    for (int i = 0; i < 2; i++) begin
      bus.instr_valid = 1'b1; bus.instr_data = instrs[i];
      cyc(); // DECODE; junk on the bus must be ignored from here on
      bus.instr_data = 8'hFF;
      n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL alu_decode_en: got %b want %b", en, EN_NONE); end
      cyc(); // READ
      n_checks++; if (en !== EN_READ) begin n_fail++; $display("FAIL alu_read_en: got %b want %b", en, EN_READ); end
      cyc(); // EXEC
      bus.instr_valid = 1'b0;
      n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL alu_exec_en: got %b want %b", en, EN_NONE); end
      n_checks++; if (bus.alu_op !== ops[i]) begin n_fail++; $display("FAIL alu_op: got %b want %b", bus.alu_op, ops[i]); end
      n_checks++; if (bus.r2 !== r2s[i]) begin n_fail++; $display("FAIL alu_r2: got %0d want %0d", bus.r2, r2s[i]); end
      cyc(); // WRITE
      n_checks++; if (en !== EN_W) begin n_fail++; $display("FAIL alu_write_en: got %b want %b", en, EN_W); end
      n_checks++; if (bus.r1 !== r1s[i]) begin n_fail++; $display("FAIL alu_r1: got %0d want %0d", bus.r1, r1s[i]); end
      n_checks++; if (bus.pc !== 8'(i)) begin n_fail++; $display("FAIL alu_pc_hold: got %0d want %0d", bus.pc, i); end
      cyc(); // FETCH
      n_checks++; if (bus.pc !== 8'(i + 1)) begin n_fail++; $display("FAIL alu_pc_inc: got %0d want %0d", bus.pc, i + 1); end
      $display("test_alu: instr=%h pc=%0d", instrs[i], bus.pc);
    end
  endtask

  task automatic test_imm();
    logic [7:0] instrs [2] = '{8'h9A, 8'hDA};
    logic [6:0] ens    [2] = '{EN_HI, EN_LO};
    for (int i = 0; i < 2; i++) begin
      bus.instr_valid = 1'b1; bus.instr_data = instrs[i];
      cyc(); // DECODE
      bus.instr_valid = 1'b0;
      n_checks++; if (bus.immediate !== 6'h0A) begin n_fail++; $display("FAIL imm_value: got %h want 0a", bus.immediate); end
      n_checks++; if (bus.r1 !== 2'd1) begin n_fail++; $display("FAIL imm_r1: got %0d want 1", bus.r1); end
      n_checks++; if (bus.r2 !== 2'd0) begin n_fail++; $display("FAIL imm_r2: got %0d want 0", bus.r2); end
      n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL imm_decode_en: got %b want %b", en, EN_NONE); end
      cyc(); // WRITE
      n_checks++; if (en !== ens[i]) begin n_fail++; $display("FAIL imm_write_en: got %b want %b", en, ens[i]); end
      cyc(); // FETCH
      n_checks++; if (bus.pc !== 8'(3 + i)) begin n_fail++; $display("FAIL imm_pc: got %0d want %0d", bus.pc, 3 + i); end
      n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL imm_fetch_en: got %b want %b", en, EN_NONE); end
      $display("test_imm: instr=%h pc=%0d", instrs[i], bus.pc);
    end
  endtask

  task automatic test_mov();
    bus.instr_valid = 1'b1; bus.instr_data = 8'h46;
    cyc(); // DECODE
    bus.instr_valid = 1'b0;
    cyc(); // WRITE
    n_checks++; if (en !== EN_SWAP) begin n_fail++; $display("FAIL mov_en: got %b want %b", en, EN_SWAP); end
    n_checks++; if ({bus.r1, bus.r2} !== 4'b0110) begin n_fail++; $display("FAIL mov_regs: got %b want 0110", {bus.r1, bus.r2}); end
    cyc(); // FETCH
    n_checks++; if (bus.pc !== 8'd5) begin n_fail++; $display("FAIL mov_pc: got %0d want 5", bus.pc); end
    $display("test_mov: instr=46 pc=%0d", bus.pc);
  endtask

  task automatic test_fetch_wait();
    bus.instr_valid = 1'b0; bus.instr_data = 8'h06;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (bus.instr_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: got %b want 1", bus.instr_req); end
      n_checks++; if (bus.pc !== 8'd5) begin n_fail++; $display("FAIL wait_pc: got %0d want 5", bus.pc); end
      n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL wait_en: got %b want %b", en, EN_NONE); end
    end
    bus.instr_valid = 1'b1; bus.instr_data = 8'h60;
    cyc(); // DECODE of NOP
    bus.instr_valid = 1'b0;
    n_checks++; if (bus.instr_req !== 1'b0) begin n_fail++; $display("FAIL wait_accept: got req %b want 0", bus.instr_req); end
    cyc(); // FETCH
    n_checks++; if (bus.pc !== 8'd6) begin n_fail++; $display("FAIL nop_pc: got %0d want 6", bus.pc); end
    $display("test_fetch_wait: pc=%0d", bus.pc);
  endtask

  task automatic test_halt();
    bus.instr_valid = 1'b1; bus.instr_data = 8'h50;
    cyc(); // DECODE
`ifdef CIRNO_CTRL_TRACE_EN
    n_checks++; if (retire_valid !== 1'b1) begin n_fail++; $display("FAIL halt_retire: got %b want 1", retire_valid); end
`endif
    bus.instr_data = 8'h06;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.instr_valid = ~bus.instr_valid;
      n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
      n_checks++; if (bus.instr_req !== 1'b0) begin n_fail++; $display("FAIL halt_req: got %b want 0", bus.instr_req); end
      n_checks++; if (bus.pc !== 8'd6) begin n_fail++; $display("FAIL halt_pc: got %0d want 6", bus.pc); end
      n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL halt_en: got %b want %b", en, EN_NONE); end
    end
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_flag: got %b want 0", bus.halted); end
    n_checks++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL halt_reset_pc: got %0d want 0", bus.pc); end
    cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++; if (bus.instr_req !== 1'b1) begin n_fail++; $display("FAIL halt_release_req: got %b want 1", bus.instr_req); end
    $display("test_halt: released, pc=%0d", bus.pc);
  endtask

  task automatic test_reset_in_write();
    bus.instr_valid = 1'b1; bus.instr_data = 8'h60;
    cyc(); // DECODE of NOP
    bus.instr_data = 8'h06;
    cyc(); // FETCH, pc=1, latches ADD
    cyc(); // DECODE
    bus.instr_valid = 1'b0;
    cyc(); // READ
    cyc(); // EXEC
    cyc(); // WRITE
    n_checks++; if (en !== EN_W) begin n_fail++; $display("FAIL rw_pre_en: got %b want %b", en, EN_W); end
    n_checks++; if (bus.pc !== 8'd1) begin n_fail++; $display("FAIL rw_pre_pc: got %0d want 1", bus.pc); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (en !== EN_NONE) begin n_fail++; $display("FAIL rw_en_drop: got %b want %b", en, EN_NONE); end
    n_checks++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL rw_pc: got %0d want 0", bus.pc); end
    n_checks++; if (bus.instr_req !== 1'b1) begin n_fail++; $display("FAIL rw_state_fetch: got req %b want 1", bus.instr_req); end
    cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL rw_release_pc: got %0d want 0", bus.pc); end
    $display("test_reset_in_write: pc=%0d", bus.pc);
  endtask

  task automatic test_wrap();
    bus.instr_valid = 1'b1; bus.instr_data = 8'h60;
    for (int i = 0; i < 255; i++) begin
      cyc();
      cyc();
    end
    n_checks++; if (bus.pc !== 8'd255) begin n_fail++; $display("FAIL wrap_pre: got %0d want 255", bus.pc); end
    cyc(); // DECODE of NOP at pc 255
`ifdef CIRNO_CTRL_TRACE_EN
    n_checks++; if (retire_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_retire_valid: got %b want 1", retire_valid); end
    n_checks++; if (retire_pc !== 8'd255) begin n_fail++; $display("FAIL wrap_retire_pc: got %0d want 255", retire_pc); end
`endif
    bus.instr_valid = 1'b0;
    cyc(); // FETCH
    n_checks++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL wrap_pc: got %0d want 0", bus.pc); end
`ifdef CIRNO_CTRL_TRACE_EN
    n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_retire_idle: got %b want 0", retire_valid); end
`endif
    $display("test_wrap: pc=%0d", bus.pc);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 8'h00;
    cyc();
    cyc();
    test_reset();
    test_alu();
    test_imm();
    test_mov();
    test_fetch_wait();
    test_halt();
    test_reset_in_write();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
